// File: rtl/seg_mux_pkg.sv
// rtl/seg_mux_pkg.sv - shared state type and default timing constants for seg_mux_scheduler
// Optional dead-time feature is selected by macro SEG_MUX_BLANK_EN in the top file.
package seg_mux_pkg;

  localparam int REFRESH_DIV_DEF  = 4000;
  localparam int BLANK_CYCLES_DEF = 40;

  typedef enum logic [1:0] {
    BLANK_A = 2'd0,
    SHOW_A  = 2'd1,
    BLANK_B = 2'd2,
    SHOW_B  = 2'd3
  } seg_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-state dwell counter with terminal-count compare
// Counts up from 0 to limit and then holds; clear restarts it on state entry.
module dwell_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == limit);

  // Saturating at limit keeps cnt parked while the FSM stalls in BLANK_A.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_mux_scheduler.sv
// rtl/seg_mux_scheduler.sv - two-digit 7-segment multiplex scheduler with tear-free shadow capture
// Macro SEG_MUX_BLANK_EN enables BLANK_B and BLANK_CYCLES dead time; otherwise BLANK_A is 1 cycle.
module seg_mux_scheduler
  import seg_mux_pkg::*;
#(
  parameter int REFRESH_DIV  = REFRESH_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s_mux,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(max2(REFRESH_DIV, BLANK_CYCLES));
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
`ifdef SEG_MUX_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] BLANK_LAST = '0;
`endif

  seg_state_e       state_q, state_d;
  logic [CNT_W-1:0] limit;
  logic             done;
  logic             advance;
  logic [3:0]       sh0_q, sh1_q;

  always_comb begin
    limit = SHOW_LAST;
    if (state_q == BLANK_A || state_q == BLANK_B) begin
      limit = BLANK_LAST;
    end
  end

  // en is only consulted at the frame boundary, i.e. the final BLANK_A cycle.
  assign advance = done && ((state_q != BLANK_A) || en);

  dwell_counter #(
    .W(CNT_W)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clear(advance),
    .limit(limit),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        BLANK_A: state_d = SHOW_A;
`ifdef SEG_MUX_BLANK_EN
        SHOW_A:  state_d = BLANK_B;
`else
        SHOW_A:  state_d = SHOW_B;
`endif
        BLANK_B: state_d = SHOW_B;
        default: state_d = BLANK_A;
      endcase
    end
  end

  // Both digits are captured together so a frame never mixes old and new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh0_q <= 4'h0;
      sh1_q <= 4'h0;
    end else if (state_q == BLANK_A && done) begin
      sh0_q <= s0;
      sh1_q <= s1;
    end
  end

  always_comb begin
    an         = 2'b11;
    s_mux      = 4'h0;
    frame_done = 1'b0;
    case (state_q)
      SHOW_A: begin
        an    = 2'b10;
        s_mux = sh0_q;
      end
      SHOW_B: begin
        an         = 2'b01;
        s_mux      = sh1_q;
        frame_done = done;
      end
      default: begin
        an    = 2'b11;
        s_mux = 4'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb/tb_seg_mux_scheduler.sv - self-checking bench for seg_mux_scheduler (REFRESH_DIV=4, BLANK_CYCLES=1)
module tb_seg_mux_scheduler;

  localparam int RD = 4;
  localparam int BC = 1;
`ifdef SEG_MUX_BLANK_EN
  localparam int P = 10;
  logic [1:0] lit_an [P] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [3:0] lit_sm [P] = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'hA, 4'hA, 4'hA, 4'hA};
  logic       lit_fd [P] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  localparam int P = 9;
  logic [1:0] lit_an [P] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [3:0] lit_sm [P] = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA, 4'hA};
  logic       lit_fd [P] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s0, s1;
  logic [3:0] s_mux;
  logic [1:0] an;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_mux_scheduler #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .s0        (s0),
    .s1        (s1),
    .s_mux     (s_mux),
    .an        (an),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Frame-level model: a whole frame is queued the moment it is committed.
  typedef struct packed {
    logic [1:0] an;
    logic [3:0] sm;
    logic       fd;
  } exp_t;

  localparam exp_t BLANK = '{an: 2'b11, sm: 4'h0, fd: 1'b0};

  exp_t q[$];
  exp_t cur;
  bit   model_valid = 0;
  bit   in_ba = 1;
  int   ba = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      in_ba       = 1;
      ba          = 0;
      cur         = BLANK;
      model_valid = 1;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!in_ba) begin
      in_ba = 1;
      ba    = 0;
      cur   = BLANK;
    end else begin
      ba++;
      if (ba >= 1 && en) begin
        for (int i = 0; i < RD; i++) q.push_back('{an: 2'b10, sm: s0, fd: 1'b0});
`ifdef SEG_MUX_BLANK_EN
        for (int i = 0; i < BC; i++) q.push_back(BLANK);
`endif
        for (int i = 0; i < RD; i++) q.push_back('{an: 2'b01, sm: s1, fd: (i == RD - 1)});
        cur   = q.pop_front();
        in_ba = 0;
      end else begin
        cur = BLANK;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_an", {6'd0, an}, {6'd0, cur.an});
      chk("model_s_mux", {4'd0, s_mux}, {4'd0, cur.sm});
      chk("model_frame_done", {7'd0, frame_done}, {7'd0, cur.fd});
      n_checks++;
      if (an == 2'b00) begin
        n_fail++;
        $display("FAIL an_never_00 at cycle %0d: got %b required not 00", cyc, an);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int c;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    s0    = 4'h3;
    s1    = 4'hA;
    repeat (3) @(negedge clk);
    chk("reset_an", {6'd0, an}, 8'h03);
    chk("reset_s_mux", {4'd0, s_mux}, 8'h00);
    chk("reset_frame_done", {7'd0, frame_done}, 8'h00);
    chk("reset_sh0", {4'd0, dut.sh0_q}, 8'h00);
    chk("reset_sh1", {4'd0, dut.sh1_q}, 8'h00);

    en    = 1'b1;
    reset = 1'b0;
    cyc   = 0;
    for (int k = 0; k < P; k++) begin
      goto(k);
      chk("frame0_an", {6'd0, an}, {6'd0, lit_an[k]});
      chk("frame0_s_mux", {4'd0, s_mux}, {4'd0, lit_sm[k]});
      chk("frame0_frame_done", {7'd0, frame_done}, {7'd0, lit_fd[k]});
    end

    goto(P + 2);
    s0 = 4'h7;
    goto(P + 4);
    chk("no_tear_s_mux", {4'd0, s_mux}, 8'h03);
    goto(2 * P + 1);
    chk("new_sample_an", {6'd0, an}, 8'h02);
    chk("new_sample_s_mux", {4'd0, s_mux}, 8'h07);

    goto(2 * P + P - 3);
    en = 1'b0;
    goto(3 * P - 1);
    chk("en_drop_frame_done", {7'd0, frame_done}, 8'h01);
    goto(3 * P + 15);
    chk("idle_an", {6'd0, an}, 8'h03);
    chk("idle_frame_done", {7'd0, frame_done}, 8'h00);

    s0 = 4'h5;
    en = 1'b1;
    c  = cyc;
    goto(c + 1);
    chk("restart_an", {6'd0, an}, 8'h02);
    chk("restart_s_mux", {4'd0, s_mux}, 8'h05);

    goto(c + P - 3);
    reset = 1'b1;
    goto(c + P - 2);
    chk("abort_an", {6'd0, an}, 8'h03);
    chk("abort_s_mux", {4'd0, s_mux}, 8'h00);
    chk("abort_frame_done", {7'd0, frame_done}, 8'h00);
    chk("abort_sh0", {4'd0, dut.sh0_q}, 8'h00);
    chk("abort_sh1", {4'd0, dut.sh1_q}, 8'h00);

    goto(c + P);
    reset = 1'b0;
    s0    = 4'hC;
    s1    = 4'h9;
    c     = cyc;
    goto(c + 3);
    en = 1'b0;
    goto(c + 5);
    en = 1'b1;
    goto(c + 3 * P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_mux_scheduler.md
SEG_MUX_SCHEDULER -- requirements
Module: seg_mux_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4000, clk cycles each digit is shown per frame (minimum 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 40, dead-time clk cycles before each digit (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run enable, sampled only at frame boundary.
REQ-006 SHALL have port s0  input  4  hex value for digit A.
REQ-007 SHALL have port s1  input  4  hex value for digit B.
REQ-008 SHALL have port s_mux  output  4  value driven into the shared segment decoder.
REQ-009 SHALL have port an  output  2  digit enables, active-low: an[0]=digit A, an[1]=digit B.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on last cycle of SHOW_B.

Function
REQ-011 SHALL implement a Moore FSM with states BLANK_A, SHOW_A, BLANK_B, SHOW_B and a dwell counter cnt that restarts at 0 on every state entry.
REQ-012 SHALL dwell BLANK_CYCLES cycles in BLANK_A and BLANK_B and REFRESH_DIV cycles in SHOW_A and SHOW_B, then advance in the order BLANK_A->SHOW_A->BLANK_B->SHOW_B->BLANK_A.
REQ-013 SHALL stay in BLANK_A with cnt held at its final value while en=0 at the last BLANK_A cycle; an en change at any other time SHALL have no effect until the next frame boundary.
REQ-014 SHALL load shadow registers sh0<=s0, sh1<=s1 on the last cycle of BLANK_A only, so both digits of a frame come from the same sample (no tearing).
REQ-015 SHALL drive outputs as a pure decode of state and shadow registers: BLANK_*: an=2'b11, s_mux=0; SHOW_A: an=2'b10, s_mux=sh0; SHOW_B: an=2'b01, s_mux=sh1.
REQ-016 SHALL never assert both an bits low in any cycle, including the cycles at reset entry and exit.
REQ-017 SHALL assert frame_done only when state=SHOW_B and cnt=REFRESH_DIV-1.
REQ-018 SHALL size cnt as $clog2 of the larger of REFRESH_DIV and BLANK_CYCLES, and SHALL not wrap cnt inside a state.

Reset
REQ-019 SHALL on reset=1 force, at the next edge, state=BLANK_A, cnt=0, sh0=sh1=0, giving an=2'b11, s_mux=0, frame_done=0.
REQ-020 SHALL let reset override en and abort any state mid-dwell, with no partial-frame output afterwards.

Configuration
REQ-021 SHALL recognise macro SEG_MUX_BLANK_EN; when defined, all behaviour above applies.
REQ-022 SHALL, without SEG_MUX_BLANK_EN, skip BLANK_B (SHOW_A->SHOW_B directly), make BLANK_A last exactly 1 cycle, and ignore BLANK_CYCLES.

Structure
REQ-023 SHALL take the state enum type and the default REFRESH_DIV and BLANK_CYCLES constants from shared package seg_mux_pkg.
REQ-024 SHALL contain the dwell counter and its terminal-count compare in a single sub-module, dwell_counter (inputs: clear, limit; output: done).
REQ-025 SHALL not instantiate the segment decoder; s_mux goes to the existing decoder at top level.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, macro defined unless noted)
REQ-026 SHALL check reset, then en=1, s0=4'h3, s1=4'hA -> cycle 0: an=11; cycles 1-4: an=10, s_mux=3; cycle 5: an=11; cycles 6-9: an=01, s_mux=A; frame_done=1 in cycle 9 only.
REQ-027 SHALL check a change of s0 to 4'h7 during SHOW_A -> s_mux stays 3 for the rest of the frame; 7 appears from the next SHOW_A.
REQ-028 SHALL check en dropped mid-SHOW_B -> the frame completes, then an=11 holds indefinitely; en=1 restores SHOW_A one cycle later.
REQ-029 SHALL check reset asserted in the 2nd cycle of SHOW_B -> the next cycle has an=11, s_mux=0, frame_done=0, sh0=sh1=0.
REQ-030 SHALL check the build without SEG_MUX_BLANK_EN -> frame period is 9 cycles: 1 BLANK_A cycle, 4 SHOW_A cycles, 4 SHOW_B cycles, with no an=11 cycle between A and B.
REQ-031 SHALL check, by assertion in every scenario, that an never equals 2'b00.
